// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: frame constants, FSM state encoding
// and the parity helper.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;

  // Even parity is the plain XOR of the data bits; odd parity inverts it.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit buffer for uart_tx: synchronous write/pop, full/empty flags, head-data
// output and a one-cycle overflow pulse for writes dropped while full.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_pop;
  logic             do_wr;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign head   = mem[rd_ptr];
  assign do_pop = pop && !empty;
  // A pop on the same edge frees a slot, so a write into a full buffer still lands.
  assign do_wr  = wr_en && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst && do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && !do_wr;
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter: 8N1 frames by default, 8-bit data plus parity and one stop
// bit when UART_TX_PARITY_EN is defined. tx is registered and idles high.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] datain,
  input  logic       wrsig,
  output logic       tx,
  output logic       idle,
  output logic       full,
  output logic       overflow
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  state_t                 state;
  logic [CW-1:0]          bit_cnt;
  logic                   bit_end;
  logic [DATA_BITS-1:0]   shreg;
  logic [2:0]             bit_idx;
  logic [DATA_BITS-1:0]   head;
  logic                   fifo_empty;
  logic                   stop_end;
  logic                   pop;

  assign bit_end  = (bit_cnt == CW'(CLKS_PER_BIT - 1));
  assign stop_end = (state == STOP) && bit_end && (bit_idx == 3'(STOP_BITS - 1));
  // Popping straight out of the last stop bit keeps consecutive frames gap-free.
  assign pop      = !fifo_empty && ((state == IDLE) || stop_end);
  assign idle     = (state == IDLE) && fifo_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wrsig),
    .wr_data  (datain),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_bit <= 1'b0;
    end else if (pop) begin
      parity_bit <= parity_of(head, PARITY_ODD != 0);
    end
  end
`else
  // Parity sense has no effect without the parity bit.
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      bit_cnt <= '0;
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      bit_cnt <= (state == IDLE || bit_end) ? '0 : bit_cnt + 1'b1;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shreg <= head;
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx      <= parity_bit;
`else
              state   <= STOP;
              tx      <= 1'b1;
`endif
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state   <= STOP;
            tx      <= 1'b1;
            bit_idx <= '0;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (stop_end) begin
              bit_idx <= '0;
              if (pop) begin
                shreg <= head;
                state <= START;
                tx    <= 1'b0;
              end else begin
                state <= IDLE;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx (CLKS_PER_BIT=16, FIFO_DEPTH=4); follows
// UART_TX_PARITY_EN for the expected frame length and parity bit.
module tb_uart_tx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int PODD  = 0;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FL   = FB * CPB;
  localparam int MAXC = 6000;

  logic       clk;
  logic       rst;
  logic [7:0] datain;
  logic       wrsig;
  logic       tx;
  logic       idle;
  logic       full;
  logic       overflow;

  int n_checks;
  int n_pass;

  logic       sched_wr   [MAXC];
  logic [7:0] sched_data [MAXC];
  logic       txs        [MAXC];
  logic       ovs        [MAXC];
  logic       fulls      [MAXC];
  logic       idles      [MAXC];

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .PARITY_ODD   (PODD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .datain   (datain),
    .wrsig    (wrsig),
    .tx       (tx),
    .idle     (idle),
    .full     (full),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level at cycle j of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int j);
    int idx;
    idx = j / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return (^b) ^ (PODD != 0);
`endif
    return 1'b1;
  endfunction

  function automatic int frame_errs(input int start, input logic [7:0] b);
    int errs;
    errs = 0;
    for (int j = 0; j < FL; j++) begin
      if (txs[start+j] !== exp_bit(b, j)) errs++;
    end
    return errs;
  endfunction

  task automatic clear_sched();
    for (int i = 0; i < MAXC; i++) begin
      sched_wr[i]   = 1'b0;
      sched_data[i] = 8'h00;
    end
  endtask

  // Sample outputs on each falling edge, then drive that cycle's scheduled write.
  task automatic capture(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      txs[c]   = tx;
      ovs[c]   = overflow;
      fulls[c] = full;
      idles[c] = idle;
      wrsig    = sched_wr[c];
      datain   = sched_data[c];
    end
    @(negedge clk);
    wrsig = 1'b0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    wrsig  = 1'b1;
    datain = 8'hFF;
    repeat (3) @(negedge clk);
    n_checks++; if (tx !== 1'b1) $display("[TB] FAIL reset_tx: got %b expected 1", tx); else n_pass++;
    n_checks++; if (idle !== 1'b1) $display("[TB] FAIL reset_idle: got %b expected 1", idle); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("[TB] FAIL reset_full: got %b expected 0", full); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); else n_pass++;
    wrsig = 1'b0;
    rst   = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (idle !== 1'b1 || tx !== 1'b1)
      $display("[TB] FAIL reset_priority: got idle=%b tx=%b expected idle=1 tx=1", idle, tx); else n_pass++;
  endtask

  task automatic test_single();
    int errs;
    clear_sched();
    sched_wr[0]   = 1'b1;
    sched_data[0] = 8'h48;
    capture(FL + 20);
    n_checks++; if (txs[1] !== 1'b1) $display("[TB] FAIL single_tx_before_start: got %b expected 1", txs[1]); else n_pass++;
    n_checks++; if (idles[1] !== 1'b0) $display("[TB] FAIL single_idle_drop: got %b expected 0", idles[1]); else n_pass++;
    n_checks++; if (txs[2] !== 1'b0) $display("[TB] FAIL single_latency: got %b expected 0", txs[2]); else n_pass++;
    for (int k = 0; k < FB; k++) begin
      errs = 0;
      for (int j = 0; j < CPB; j++) begin
        if (txs[2 + k*CPB + j] !== exp_bit(8'h48, k*CPB + j)) errs++;
      end
      n_checks++;
      if (errs != 0) $display("[TB] FAIL single_bit%0d: got %0d wrong samples expected 0", k, errs); else n_pass++;
    end
`ifdef UART_TX_PARITY_EN
    n_checks++;
    if (txs[2 + 9*CPB + 8] !== ((PODD != 0) ? 1'b1 : 1'b0))
      $display("[TB] FAIL single_parity: got %b expected %b", txs[2 + 9*CPB + 8], (PODD != 0)); else n_pass++;
`endif
    n_checks++; if (idles[1+FL] !== 1'b0) $display("[TB] FAIL single_idle_in_stop: got %b expected 0", idles[1+FL]); else n_pass++;
    n_checks++; if (idles[2+FL] !== 1'b1 || txs[2+FL] !== 1'b1)
      $display("[TB] FAIL single_idle_after: got idle=%b tx=%b expected 1 1", idles[2+FL], txs[2+FL]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int errs;
    int ov_count;
    clear_sched();
    for (int i = 0; i < 6; i++) begin
      sched_wr[i]   = 1'b1;
      sched_data[i] = 8'(i + 1);
    end
    capture(5*FL + 40);
    n_checks++; if (fulls[5] !== 1'b1) $display("[TB] FAIL b2b_full: got %b expected 1", fulls[5]); else n_pass++;
    n_checks++; if (ovs[6] !== 1'b1) $display("[TB] FAIL b2b_overflow_pulse: got %b expected 1", ovs[6]); else n_pass++;
    ov_count = 0;
    for (int c = 0; c < 5*FL + 40; c++) if (ovs[c] === 1'b1) ov_count++;
    n_checks++; if (ov_count != 1) $display("[TB] FAIL b2b_overflow_count: got %0d expected 1", ov_count); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      errs = frame_errs(2 + k*FL, 8'(k + 1));
      n_checks++;
      if (errs != 0) $display("[TB] FAIL b2b_frame%0d: got %0d wrong samples expected 0", k + 1, errs); else n_pass++;
    end
    errs = 0;
    for (int c = 2 + 5*FL; c < 5*FL + 40; c++) if (txs[c] !== 1'b1) errs++;
    n_checks++; if (errs != 0) $display("[TB] FAIL b2b_no_sixth: got %0d low samples expected 0", errs); else n_pass++;
    n_checks++; if (idle !== 1'b1) $display("[TB] FAIL b2b_idle_end: got %b expected 1", idle); else n_pass++;
  endtask

  task automatic test_pop_collision();
    int errs;
    int ov_count;
    logic [7:0] bytes [6];
    bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    clear_sched();
    for (int i = 0; i < 5; i++) begin
      sched_wr[i]   = 1'b1;
      sched_data[i] = bytes[i];
    end
    sched_wr[1+FL]   = 1'b1;
    sched_data[1+FL] = bytes[5];
    capture(6*FL + 40);
    n_checks++; if (fulls[1+FL] !== 1'b1) $display("[TB] FAIL pop_full_before: got %b expected 1", fulls[1+FL]); else n_pass++;
    n_checks++; if (fulls[2+FL] !== 1'b1) $display("[TB] FAIL pop_full_after: got %b expected 1", fulls[2+FL]); else n_pass++;
    ov_count = 0;
    for (int c = 0; c < 6*FL + 40; c++) if (ovs[c] === 1'b1) ov_count++;
    n_checks++; if (ov_count != 0) $display("[TB] FAIL pop_overflow: got %0d pulses expected 0", ov_count); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      errs = frame_errs(2 + k*FL, bytes[k]);
      n_checks++;
      if (errs != 0) $display("[TB] FAIL pop_frame%0d: got %0d wrong samples expected 0", k, errs); else n_pass++;
    end
  endtask

  task automatic test_reset_midframe();
    int errs;
    clear_sched();
    sched_wr[0] = 1'b1; sched_data[0] = 8'h5A;
    sched_wr[1] = 1'b1; sched_data[1] = 8'h33;
    sched_wr[2] = 1'b1; sched_data[2] = 8'hCC;
    capture(50);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (tx !== 1'b1) $display("[TB] FAIL rstmid_tx: got %b expected 1", tx); else n_pass++;
    n_checks++; if (idle !== 1'b1) $display("[TB] FAIL rstmid_idle: got %b expected 1", idle); else n_pass++;
    n_checks++; if (full !== 1'b0 || overflow !== 1'b0)
      $display("[TB] FAIL rstmid_flags: got full=%b overflow=%b expected 0 0", full, overflow); else n_pass++;
    rst = 1'b0;
    clear_sched();
    capture(400);
    errs = 0;
    for (int c = 0; c < 400; c++) if (txs[c] !== 1'b1 || idles[c] !== 1'b1) errs++;
    n_checks++; if (errs != 0) $display("[TB] FAIL rstmid_no_frames: got %0d bad samples expected 0", errs); else n_pass++;
  endtask

  task automatic test_hello();
    int errs;
    int bad_frames;
    int ov_count;
    logic [7:0] msg [20];
    msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h41, 8'h4C, 8'h49, 8'h4E,
            8'h58, 8'h20, 8'h41, 8'h58, 8'h35, 8'h31, 8'h36, 8'h20, 8'h0A, 8'h0D};
    clear_sched();
    for (int k = 0; k < 20; k++) begin
      sched_wr[k*255]   = 1'b1;
      sched_data[k*255] = msg[k];
    end
    capture(20*255 + 40);
    bad_frames = 0;
    for (int k = 0; k < 20; k++) begin
      errs = frame_errs(2 + k*255, msg[k]);
      if (errs != 0) begin
        bad_frames++;
        $display("[TB] FAIL hello_byte%0d: got %0d wrong samples expected 0", k, errs);
      end
    end
    n_checks++; if (bad_frames == 0) n_pass++;
    ov_count = 0;
    for (int c = 0; c < 20*255 + 40; c++) if (ovs[c] === 1'b1) ov_count++;
    n_checks++; if (ov_count != 0) $display("[TB] FAIL hello_overflow: got %0d pulses expected 0", ov_count); else n_pass++;
    n_checks++; if (idle !== 1'b1) $display("[TB] FAIL hello_idle_end: got %b expected 1", idle); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    wrsig    = 1'b0;
    datain   = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_pop_collision();
    test_reset_midframe();
    test_hello();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit (clk is the 16x baud clock).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: transmit buffer entries, power of two, 2..16.
REQ-003 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity (used only with the parity feature).
REQ-004 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port datain  input  8: byte to send, sampled when wrsig=1.
REQ-007 SHALL have port wrsig  input  1: one-cycle write strobe from the upstream controller.
REQ-008 SHALL have port tx  output  1: serial line, idle high.
REQ-009 SHALL have port idle  output  1: high when the FSM is in IDLE and the FIFO is empty.
REQ-010 SHALL have port full  output  1: FIFO holds FIFO_DEPTH entries.
REQ-011 SHALL have port overflow  output  1: one-cycle pulse when a write is dropped.

Function
REQ-012 SHALL write datain into the FIFO on any edge with wrsig=1 and FIFO not full; a wrsig held high writes once per cycle.
REQ-013 SHALL drop a write arriving while full and no pop occurs that cycle, and pulse overflow high for exactly the next cycle.
REQ-014 SHALL accept a write when full if a pop occurs on the same edge; occupancy stays unchanged.
REQ-015 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL pop the FIFO head in IDLE when the FIFO is non-empty, load the shift register and enter START on the same edge.
REQ-017 SHALL give a latency of 2 edges: wrsig sampled at edge E into an empty FIFO with FSM IDLE -> tx low from edge E+1.
REQ-018 SHALL hold each bit for exactly CLKS_PER_BIT cycles using a bit-period counter that restarts at 0 on every state change.
REQ-019 SHALL send the frame as: START tx=0; DATA 8 bits LSB first; PARITY if enabled; STOP tx=1 for one bit.
REQ-020 SHALL leave STOP at the end of the bit for IDLE, or pop directly into START if the FIFO is non-empty (no idle gap between frames).
REQ-021 SHALL register tx (no combinational path from inputs to tx).
REQ-022 SHALL size the bit counter to ceil(log2(CLKS_PER_BIT)) bits and the FIFO pointers to wrap modulo FIFO_DEPTH.

Reset
REQ-023 SHALL, while rst=1, force tx=1, idle=1, full=0, overflow=0, FSM=IDLE, FIFO empty, all counters 0; rst takes priority over wrsig.
REQ-024 SHALL abort any frame in flight on rst (tx high from the next edge) and discard buffered bytes.

Configuration
REQ-025 SHALL insert a PARITY state after DATA when macro UART_TX_PARITY_EN is defined, sending the XOR of the 8 data bits (inverted when PARITY_ODD=1), for an 11-bit frame.
REQ-026 SHALL omit the PARITY state and its logic when UART_TX_PARITY_EN is undefined, for a 10-bit frame.

Structure
REQ-027 SHALL place the FSM state encoding typedef and the frame constants (DATA_BITS=8, STOP_BITS=1) in the shared package uart_pkg.
REQ-028 SHALL implement the FIFO as sub-module uart_tx_fifo with synchronous write/pop, full/empty flags and head-data output.

Verification
REQ-029 SHALL cover: single write 0x48, no parity -> tx sequence 0,0,0,0,1,0,0,1,0,1, each bit 16 clks, idle high again 160 clks after the start edge.
REQ-030 SHALL cover: UART_TX_PARITY_EN, PARITY_ODD=0, write 0x48 -> parity bit 0; with PARITY_ODD=1 -> parity bit 1; frame 176 clks.
REQ-031 SHALL cover: wrsig high for 6 consecutive cycles (0x01..0x06) -> 0x01..0x05 sent back-to-back with no gap, 0x06 dropped, a single overflow pulse, full high during that cycle.
REQ-032 SHALL cover: wrsig at the same edge the FSM pops from a full FIFO -> byte accepted, overflow stays 0.
REQ-033 SHALL cover: rst asserted mid-DATA with 2 bytes queued -> tx=1 next edge, idle=1, no further frames after rst is released.
REQ-034 SHALL cover: 20-byte "Hello ALINX AX516 \n\r" written one byte every 255 clks -> all 20 bytes received intact, overflow never asserted.
